// File: rtl/spi_pkg.sv
// Shared state encoding and frame constants for the SPI register-file slave.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StDone
  } spi_state_e;

  localparam int unsigned HDR_W       = 8;
  localparam int unsigned WR_FLAG_BIT = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI input, with leading/trailing edge flags
// derived from the synchronised level and one extra history flop.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CPOL        = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic lead,
  output logic trail
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    sync_out = sync_q[SYNC_STAGES-1];
    rise     = sync_out & ~prev_q;
    fall     = ~sync_out & prev_q;
    // With CPOL=1 the clock idles high, so the leading edge is the falling one.
    lead     = (CPOL != 0) ? fall : rise;
    trail    = (CPOL != 0) ? rise : fall;
  end

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI (CPHA=0) slave exposing a bank of read registers and a bank of write registers.
// Frame: 8-bit header (write flag + address) followed by DATA_W payload bits, MSB first.
module spi_regfile_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned N_RD        = 16,
  parameter int unsigned N_WR        = 16,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spi_clk,
  input  logic                   spi_cs,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  input  logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_WR*DATA_W-1:0] wr_data,
  output logic                   wr_strobe,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [7:0]             frame_err_cnt
);

  localparam int unsigned FRAME_W = HDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  logic clk_s, clk_lead, clk_trail;
  logic cs_s, cs_lead, cs_trail;
  logic mosi_s, mosi_lead, mosi_trail;
  logic unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .CPOL(CPOL)) u_sync_clk (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_clk),
    .sync_out (clk_s),
    .lead     (clk_lead),
    .trail    (clk_trail)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .CPOL(0)) u_sync_cs (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_cs),
    .sync_out (cs_s),
    .lead     (cs_lead),
    .trail    (cs_trail)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .CPOL(0)) u_sync_mosi (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_mosi),
    .sync_out (mosi_s),
    .lead     (mosi_lead),
    .trail    (mosi_trail)
  );

  assign unused_sync = ^{clk_s, cs_lead, cs_trail, mosi_lead, mosi_trail};

  spi_state_e              state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [DATA_W-1:0]       miso_sh_q, miso_sh_d;
  logic                    miso_q, miso_d;
  logic                    hdr_wr_q, hdr_wr_d;
  logic [ADDR_W-1:0]       hdr_addr_q, hdr_addr_d;
  // Cleared by reset; set once CS is seen high so a frame cut by reset is not resumed.
  logic                    armed_q, armed_d;
  logic [N_WR*DATA_W-1:0]  wr_data_q, wr_data_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0]       rd_word;
  logic                    rd_oob, wr_oob, wr_en, err_inc;

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < N_RD; k++) begin
      if (shift_q[ADDR_W-1:0] == ADDR_W'(k)) rd_word = rd_data[k*DATA_W +: DATA_W];
    end
    rd_oob = 32'(shift_q[ADDR_W-1:0]) >= N_RD;
    wr_oob = 32'(hdr_addr_q) >= N_WR;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    miso_sh_d   = miso_sh_q;
    miso_d      = miso_q;
    hdr_wr_d    = hdr_wr_q;
    hdr_addr_d  = hdr_addr_q;
    armed_d     = armed_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_en       = 1'b0;
    err_inc     = 1'b0;

    if (cs_s) begin
      state_d = StIdle;
      miso_d  = 1'b0;
      armed_d = 1'b1;
      err_inc = (state_q == StHdr) || (state_q == StData);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (armed_q) begin
            state_d   = StHdr;
            bit_cnt_d = '0;
            shift_d   = '0;
            miso_sh_d = '0;
            miso_d    = 1'b0;
          end
        end
        StHdr, StData: begin
          if (clk_lead && (bit_cnt_q < CNT_W'(FRAME_W))) begin
            shift_d   = {shift_q[DATA_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (clk_trail && (state_q == StHdr) && (bit_cnt_q == CNT_W'(HDR_W))) begin
            hdr_wr_d   = shift_q[WR_FLAG_BIT];
            hdr_addr_d = shift_q[ADDR_W-1:0];
            miso_sh_d  = rd_word;
            miso_d     = rd_word[DATA_W-1];
            state_d    = StData;
            err_inc    = rd_oob && !shift_q[WR_FLAG_BIT];
          end else if (clk_trail && (state_q == StData)) begin
            if (bit_cnt_q == CNT_W'(FRAME_W)) begin
              state_d = StDone;
              miso_d  = 1'b0;
              if (hdr_wr_q) begin
                if (wr_oob) begin
                  err_inc = 1'b1;
                end else begin
                  wr_en       = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = hdr_addr_q;
                end
              end
            end else begin
              miso_sh_d = {miso_sh_q[DATA_W-2:0], 1'b0};
              miso_d    = miso_sh_q[DATA_W-2];
            end
          end
        end
        StDone: miso_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    wr_data_d = wr_data_q;
    for (int unsigned k = 0; k < N_WR; k++) begin
      if (wr_en && (hdr_addr_q == ADDR_W'(k))) wr_data_d[k*DATA_W +: DATA_W] = shift_q;
    end
    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      miso_sh_q   <= '0;
      miso_q      <= 1'b0;
      hdr_wr_q    <= 1'b0;
      hdr_addr_q  <= '0;
      armed_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      miso_sh_q   <= miso_sh_d;
      miso_q      <= miso_d;
      hdr_wr_q    <= hdr_wr_d;
      hdr_addr_q  <= hdr_addr_d;
      armed_q     <= armed_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign spi_miso      = miso_q;
  assign wr_data       = wr_data_q;
  assign wr_strobe     = wr_strobe_q;
  assign wr_addr       = wr_addr_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Scoreboard bench: three slave instances (default, 4-register banks, 16-bit CPOL=1) on
// one bench-driven SPI bus with separate chip selects; monitors check MISO words and strobes.
`timescale 1ns/1ps
module tb_spi_regfile_slave;

  localparam int HALF = 60;

  logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, sclk_n, mosi = 1'b0;
  logic cs0 = 1'b1, cs1 = 1'b1, cs2 = 1'b1, cs_all;
  logic miso0, miso1, miso2;
  logic [511:0] rd_data0, wr_data0;
  logic [127:0] rd_data1, wr_data1;
  logic [255:0] rd_data2, wr_data2;
  logic wr_strobe0, wr_strobe1, wr_strobe2;
  logic [3:0] wr_addr0, wr_addr1, wr_addr2;
  logic [7:0] err0, err1, err2;

  typedef struct {
    int          d;
    logic [3:0]  a;
    logic [63:0] v;
  } wr_exp_t;

  wr_exp_t     exp_wr_q[$];
  logic [63:0] exp_rd_q[$];
  int          checks = 0, failures = 0;
  int          strb_cnt[3] = '{0, 0, 0};
  logic        strb_prev[3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  assign sclk_n = ~sclk;
  assign cs_all = cs0 & cs1 & cs2;

  spi_regfile_slave dut0 (
    .clk(clk), .reset(reset), .spi_clk(sclk), .spi_cs(cs0), .spi_mosi(mosi), .spi_miso(miso0),
    .rd_data(rd_data0), .wr_data(wr_data0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0),
    .frame_err_cnt(err0)
  );

  spi_regfile_slave #(.N_RD(4), .N_WR(4)) dut1 (
    .clk(clk), .reset(reset), .spi_clk(sclk), .spi_cs(cs1), .spi_mosi(mosi), .spi_miso(miso1),
    .rd_data(rd_data1), .wr_data(wr_data1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1),
    .frame_err_cnt(err1)
  );

  spi_regfile_slave #(.DATA_W(16), .CPOL(1)) dut2 (
    .clk(clk), .reset(reset), .spi_clk(sclk_n), .spi_cs(cs2), .spi_mosi(mosi),
    .spi_miso(miso2), .rd_data(rd_data2), .wr_data(wr_data2), .wr_strobe(wr_strobe2),
    .wr_addr(wr_addr2), .frame_err_cnt(err2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic miso_of(input int d);
    return (d == 0) ? miso0 : ((d == 1) ? miso1 : miso2);
  endfunction

  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs0 = v;
    else if (d == 1) cs1 = v;
    else cs2 = v;
  endtask

  task automatic chk_wr(input int d, input logic [3:0] a, input logic [63:0] v);
    wr_exp_t e;
    strb_cnt[d]++;
    if (exp_wr_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL wr_strobe: unexpected strobe on dut%0d addr=%h data=%h", d, a, v);
    end else begin
      e = exp_wr_q.pop_front();
      check("wr_dut", 64'(d), 64'(e.d));
      check("wr_addr", 64'(a), 64'(e.a));
      check("wr_data", v, e.v);
    end
  endtask

  // Strobe monitor: compares each committed write against the expected queue.
  always @(negedge clk) begin
    if (wr_strobe0) chk_wr(0, wr_addr0, 64'(wr_data0[wr_addr0*32 +: 32]));
    if (wr_strobe1) chk_wr(1, wr_addr1, 64'(wr_data1[wr_addr1[1:0]*32 +: 32]));
    if (wr_strobe2) chk_wr(2, wr_addr2, 64'(wr_data2[wr_addr2*16 +: 16]));
    if (wr_strobe0 && strb_prev[0]) check("strobe_width0", 64'd1, 64'd0);
    if (wr_strobe1 && strb_prev[1]) check("strobe_width1", 64'd1, 64'd0);
    if (wr_strobe2 && strb_prev[2]) check("strobe_width2", 64'd1, 64'd0);
    strb_prev[0] = wr_strobe0;
    strb_prev[1] = wr_strobe1;
    strb_prev[2] = wr_strobe2;
  end

  // MISO monitor: samples like the host on leading edges; payload-window bits form the word.
  initial begin : miso_mon
    int d, fw, n;
    logic [63:0] w, e;
    forever begin
      @(negedge cs_all);
      d  = !cs0 ? 0 : (!cs1 ? 1 : 2);
      fw = (d == 2) ? 24 : 40;
      n  = 0;
      w  = '0;
      while (!cs_all) begin
        @(posedge sclk or posedge cs_all);
        if (!cs_all) begin
          #1;
          n++;
          if (n > 8 && n <= fw) w = {w[62:0], miso_of(d)};
          else if (n > fw) check("done_miso", 64'(miso_of(d)), 64'd0);
        end
      end
      if (n >= fw) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL miso_word: got %h with no expected entry", w);
        end else begin
          e = exp_rd_q.pop_front();
          check("miso_word", w, e);
        end
      end
    end
  end

  task automatic spi_frame(input int d, input logic [7:0] hdr, input logic [63:0] data,
                           input int dw, input int nbits, input int rst_at);
    set_cs(d, 1'b0);
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        #30;
        reset = 1'b0;
      end
      if (i < 8) mosi = hdr[7-i];
      else if (i < 8 + dw) mosi = data[dw-1-(i-8)];
      else mosi = 1'b0;
      #(HALF);
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    #(HALF);
    set_cs(d, 1'b1);
    #(4*HALF);
  endtask

  initial begin
    rd_data0 = '0;
    rd_data0[3*32 +: 32] = 32'h0BAD_F00D;
    rd_data0[2*32 +: 32] = 32'h1234_5678;
    rd_data1 = {4{32'hFFFF_FFFF}};
    rd_data2 = {16{16'h1111}};
    rd_data2[5*16 +: 16] = 16'h5A5A;

    @(posedge clk);
    @(negedge clk);
    check("rst_miso", 64'(miso0), 64'd0);
    check("rst_wr_data", 64'(|wr_data0), 64'd0);
    check("rst_strobe", 64'(wr_strobe0), 64'd0);
    check("rst_wr_addr", 64'(wr_addr0), 64'd0);
    check("rst_err", 64'(err0), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 4-register banks: read and write to address 9 both out of range.
    exp_rd_q.push_back(64'd0);
    spi_frame(1, 8'h09, 64'd0, 32, 40, -1);
    exp_rd_q.push_back(64'd0);
    spi_frame(1, 8'h89, 64'h1122_3344, 32, 40, -1);
    check("oob_err", 64'(err1), 64'd2);
    check("oob_wr_data", 64'(|wr_data1), 64'd0);
    check("oob_strobes", 64'(strb_cnt[1]), 64'd0);

    // 16-bit CPOL=1 write with 10 extra clocks after the frame.
    exp_rd_q.push_back(64'h5A5A);
    exp_wr_q.push_back('{d: 2, a: 4'd5, v: 64'hA5A5});
    spi_frame(2, 8'h85, 64'hA5A5, 16, 34, -1);
    check("cpol1_slice5", 64'(wr_data2[5*16 +: 16]), 64'hA5A5);
    check("cpol1_strobes", 64'(strb_cnt[2]), 64'd1);
    check("cpol1_err", 64'(err2), 64'd0);

    // Default instance: write, read, aborted write.
    exp_rd_q.push_back(64'h0BAD_F00D);
    exp_wr_q.push_back('{d: 0, a: 4'd3, v: 64'hDEAD_BEEF});
    spi_frame(0, 8'h83, 64'hDEAD_BEEF, 32, 40, -1);
    check("wr_err", 64'(err0), 64'd0);
    exp_rd_q.push_back(64'h1234_5678);
    spi_frame(0, 8'h02, 64'd0, 32, 40, -1);
    spi_frame(0, 8'h81, 64'hCAFE_F00D, 32, 20, -1);
    check("abort_err", 64'(err0), 64'd1);
    check("abort_slice1", 64'(wr_data0[1*32 +: 32]), 64'd0);
    check("slice3", 64'(wr_data0[3*32 +: 32]), 64'hDEAD_BEEF);
    check("wr_addr3", 64'(wr_addr0), 64'd3);
    check("strobes_a", 64'(strb_cnt[0]), 64'd1);

    // Reset mid-frame, then a clean write to address 1.
    exp_rd_q.push_back(64'd0);
    spi_frame(0, 8'h81, 64'hFFFF_0000, 32, 40, 30);
    exp_rd_q.push_back(64'd0);
    exp_wr_q.push_back('{d: 0, a: 4'd1, v: 64'd1});
    spi_frame(0, 8'h81, 64'd1, 32, 40, -1);
    check("rst_frame_err", 64'(err0), 64'd0);
    check("rst_slice1", 64'(wr_data0[1*32 +: 32]), 64'd1);
    check("rst_slice3", 64'(wr_data0[3*32 +: 32]), 64'd0);
    check("rst_wr_addr1", 64'(wr_addr0), 64'd1);
    check("strobes_b", 64'(strb_cnt[0]), 64'd2);
    check("wr_pending", 64'(exp_wr_q.size()), 64'd0);
    check("rd_pending", 64'(exp_rd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_regfile_slave.md
SPI_REGFILE_SLAVE -- requirements
Module: spi_regfile_slave

Interface
REQ-001 Parameter DATA_W, default 32: payload bits per frame, 8..64.
REQ-002 Parameter ADDR_W, default 4: register address bits, 1..7.
REQ-003 Parameter N_RD, default 16: number of FPGA-to-host read registers, at most 2**ADDR_W.
REQ-004 Parameter N_WR, default 16: number of host-to-FPGA write registers, at most 2**ADDR_W.
REQ-005 Parameter CPOL, default 0: SPI clock idle level; CPHA is fixed at 0.
REQ-006 Parameter SYNC_STAGES, default 2: synchroniser depth for SPI inputs, at least 2.
REQ-007 Timing: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  system clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 spi_clk  in  1  asynchronous SPI clock from host.
REQ-011 spi_cs  in  1  asynchronous chip select, active-low.
REQ-012 spi_mosi  in  1  asynchronous host data.
REQ-013 spi_miso  out  1  registered slave data.
REQ-014 rd_data  in  N_RD*DATA_W  flattened read registers; register k is at bits [k*DATA_W +: DATA_W].
REQ-015 wr_data  out  N_WR*DATA_W  flattened write registers, using the same packing as rd_data.
REQ-016 wr_strobe  out  1  one-clk pulse when a write commits.
REQ-017 wr_addr  out  ADDR_W  address of the last committed write.
REQ-018 frame_err_cnt  out  8  saturating count of aborted or invalid frames.

Function
REQ-019 spi_clk, spi_cs and spi_mosi shall each pass through SYNC_STAGES flops before use.
- Edges are detected from the last two synchronised spi_clk stages.
- The leading edge is rising when CPOL=0 and falling when CPOL=1.
REQ-020 Frame format, MSB first, 8+DATA_W bits:
- header bit7 = write flag;
- header bits[ADDR_W-1:0] = address;
- the other header bits are ignored;
- then DATA_W payload bits.
REQ-021 FSM states IDLE, HDR, DATA, DONE; reset and any synchronised spi_cs=1 force IDLE on the next clk.
REQ-022 IDLE -> HDR on synchronised spi_cs=0; on that transition the shift register and bit counter clear and spi_miso=0.
REQ-023 In HDR and DATA, each leading edge shifts the synchronised MOSI into the shift register and increments the bit counter.
REQ-024 In HDR, on the trailing edge after bit 8, capture the read word from the header address into the MISO shifter, drive its MSB on spi_miso, and enter DATA.
REQ-025 In DATA, each trailing edge shifts the next MISO bit out.
- After the last payload bit, enter DONE.
- Commit the write if the write flag is set.
REQ-026 A read from an address >= N_RD shall return all zeros and increment frame_err_cnt once.
REQ-027 A write commit (address < N_WR) shall:
- update the addressed wr_data slice;
- set wr_addr;
- pulse wr_strobe for exactly one clk, one clk after the final trailing edge is detected.
REQ-028 A write to an address >= N_WR shall be discarded (no strobe) and increment frame_err_cnt.
REQ-029 spi_cs rising in HDR or DATA shall abort the frame with no write and no strobe, and increment frame_err_cnt.
REQ-030 In DONE, further SPI clock edges shall be ignored and spi_miso held 0 until spi_cs rises.
REQ-031 frame_err_cnt shall saturate at 255.
REQ-032 rd_data is sampled only at the REQ-024 capture; later changes do not affect the frame in flight.
REQ-033 Worst-case latency from an SPI edge to an internal action is SYNC_STAGES+1 clk; the required clk frequency is at least 8x the spi_clk frequency.

Reset
REQ-034 On reset, all of the following shall clear within one clk:
- state = IDLE;
- spi_miso = 0;
- wr_data = 0;
- wr_strobe = 0;
- wr_addr = 0;
- frame_err_cnt = 0;
- counter and shifters = 0.
REQ-035 Reset asserted mid-frame discards the frame without a strobe or error count; the current frame is ignored until spi_cs goes high then low again.

Structure
REQ-036 Package spi_pkg shall hold:
- the FSM state enum;
- the header width constant HDR_W = 8;
- the write-flag bit index constant.
REQ-037 One sub-module, spi_sync_edge, shall implement the synchroniser plus leading/trailing edge detect; it is instantiated for spi_clk, and the same synchroniser is used for spi_cs and spi_mosi.

Verification
REQ-038 Default parameters, CPOL=0, write frame 0x83 + 0xDEADBEEF -> wr_data slice 3 = 0xDEADBEEF, wr_addr=3, one wr_strobe pulse, frame_err_cnt=0.
REQ-039 rd_data slice 2 = 0x12345678, read frame 0x02 + 32 dummy bits -> spi_miso returns 0x12345678 MSB first; no strobe.
REQ-040 spi_cs raised after 20 bits of a write to address 1 -> wr_data unchanged, no strobe, frame_err_cnt=1.
REQ-041 N_RD=N_WR=4, frames to address 9 (read and write) -> MISO returns 0, no strobe, frame_err_cnt=2.
REQ-042 DATA_W=16, CPOL=1, write 0x85 + 0xA5A5, then 10 extra clocks before spi_cs rises -> slice 5 = 0xA5A5, a single strobe, spi_miso=0 during the extras.
REQ-043 Reset pulsed at bit 30 of a write frame, then a clean write of 0x81 + 0x00000001 -> only the second frame commits; frame_err_cnt=0.
